// File: rtl/mips_pkg.sv
// Shared types for the MIPS hazard/forwarding controller: mux select encoding,
// controller states and the shadow-pipeline slot record.
package mips_pkg;

  localparam int unsigned MIPS_REG_AW = 5;
  localparam int unsigned SLOTS       = 3;
  localparam int unsigned SLOT_EX     = 0;
  localparam int unsigned SLOT_MEM    = 1;
  localparam int unsigned SLOT_WB     = 2;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LDUSE  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                   valid;
    logic [MIPS_REG_AW-1:0] dest;
    logic                   reg_write;
    logic                   mem_read;
  } slot_t;

  // A slot can supply a source operand only if it really writes a non-zero register.
  function automatic logic slot_hit(input slot_t s, input logic [MIPS_REG_AW-1:0] src,
                                    input logic use_src);
    return use_src && s.valid && s.reg_write && (s.dest != '0) && (s.dest == src);
  endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// ID-stage hazard information in, pipeline control and forwarding selects out.
interface mips_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              mem_stall;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write,
           id_mem_read, ex_branch_taken, mem_stall,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write,
           id_mem_read, ex_branch_taken, mem_stall,
    output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/mips_hazard_ctrl_fwd_sel_gen.sv
// Compares one ID source register against the EX and MEM shadow slots and
// produces the operand mux select plus a load-use hit flag.
module fwd_sel_gen
  import mips_pkg::*;
(
  input  logic [MIPS_REG_AW-1:0] src,
  input  logic                   use_src,
  input  slot_t                  ex,
  input  slot_t                  mem,
  output fwd_sel_t               sel,
  output logic                   load_hit
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = slot_hit(ex, src, use_src);
  assign mem_hit = slot_hit(mem, src, use_src);

  // Youngest producer wins; a load in EX cannot forward and is reported instead.
  always_comb begin
    sel      = FWD_REG;
    load_hit = 1'b0;
    if (ex_hit && ex.mem_read) begin
      load_hit = 1'b1;
    end
    if (ex_hit && !ex.mem_read) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipe: shadow EX/MEM/WB slots,
// registered ALU operand selects, load-use stall, branch flush and memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = MIPS_REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  mips_hazard_ctrl_if.slave hz
);

  hz_state_t   state_q, state_d, saved_q, saved_d, eff_state;
  slot_t       shadow [SLOTS];
  slot_t       id_slot;
  fwd_sel_t    sel_a, sel_b, fwd_a_q, fwd_b_q;
  logic        load_a, load_b, load_use;
  logic        freeze, ld_stall, flush;
  logic [REG_AW-1:0] rs, rt, dest;

  assign rs   = hz.id_rs;
  assign rt   = hz.id_rt;
  assign dest = hz.id_dest;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = hz.id_valid;
    id_slot.dest      = MIPS_REG_AW'(dest);
    id_slot.reg_write = hz.id_reg_write;
    id_slot.mem_read  = hz.id_mem_read;
  end

  fwd_sel_gen u_fwd_a (
    .src      (MIPS_REG_AW'(rs)),
    .use_src  (hz.id_valid & hz.id_use_rs),
    .ex       (shadow[SLOT_EX]),
    .mem      (shadow[SLOT_MEM]),
    .sel      (sel_a),
    .load_hit (load_a)
  );

  fwd_sel_gen u_fwd_b (
    .src      (MIPS_REG_AW'(rt)),
    .use_src  (hz.id_valid & hz.id_use_rt),
    .ex       (shadow[SLOT_EX]),
    .mem      (shadow[SLOT_MEM]),
    .sel      (sel_b),
    .load_hit (load_b)
  );

  assign load_use  = load_a | load_b;
  // While frozen the controller behaves as the state it was in before the freeze.
  assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

  always_comb begin
    state_d        = state_q;
    saved_d        = saved_q;
    freeze         = 1'b0;
    ld_stall       = 1'b0;
    flush          = 1'b0;
    hz.pc_we       = 1'b1;
    hz.ifid_we     = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (!rst_n) begin
      state_d = RUN;
      saved_d = RUN;
    end else if (hz.mem_stall) begin
      freeze     = 1'b1;
      hz.pc_we   = 1'b0;
      hz.ifid_we = 1'b0;
      state_d    = FREEZE;
      if (state_q != FREEZE) begin
        saved_d = state_q;
      end
    end else if (hz.ex_branch_taken) begin
      flush          = 1'b1;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      state_d        = RUN;
    end else if (eff_state == RUN && load_use) begin
      ld_stall       = 1'b1;
      hz.pc_we       = 1'b0;
      hz.ifid_we     = 1'b0;
      hz.idex_bubble = 1'b1;
      state_d        = LDUSE;
    end else begin
      state_d = RUN;
    end
  end

  // State, shadow pipeline and operand selects; all hold while frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      shadow  <= '{default: '0};
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      if (!freeze) begin
        shadow[SLOT_WB]  <= shadow[SLOT_MEM];
        shadow[SLOT_MEM] <= shadow[SLOT_EX];
        if (flush || ld_stall) begin
          shadow[SLOT_EX] <= '0;
          fwd_a_q         <= FWD_REG;
          fwd_b_q         <= FWD_REG;
        end else begin
          shadow[SLOT_EX] <= id_slot;
          fwd_a_q         <= sel_a;
          fwd_b_q         <= sel_b;
        end
      end
    end
  end

  assign hz.fwd_a_sel = fwd_a_q;
  assign hz.fwd_b_sel = fwd_b_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((freeze || ld_stall) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed, table-driven bench for mips_hazard_ctrl (forwarding, load-use,
// flush, freeze, reset and optional counters).
module tb_mips_hazard_ctrl;

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       br;
    logic       ms;
    logic       pc;
    logic       ifid;
    logic       fl;
    logic       bub;
    logic [1:0] sa;
    logic [1:0] sb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mips_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hz ();

  mips_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  function automatic vec_t mk(input string nm, input int v, input int rs, input int rt,
                              input int urs, input int urt, input int dest, input int rw,
                              input int mr, input int br, input int ms, input int pc,
                              input int ifid, input int fl, input int bub, input int sa,
                              input int sb);
    vec_t r;
    r.name = nm;    r.v  = 1'(v);    r.rs   = 5'(rs);   r.rt  = 5'(rt);
    r.urs  = 1'(urs); r.urt = 1'(urt); r.dest = 5'(dest); r.rw  = 1'(rw);
    r.mr   = 1'(mr);  r.br  = 1'(br);  r.ms   = 1'(ms);   r.pc  = 1'(pc);
    r.ifid = 1'(ifid); r.fl = 1'(fl);  r.bub  = 1'(bub);  r.sa  = 2'(sa);
    r.sb   = 2'(sb);
    return r;
  endfunction

  // Ordinary instruction in ID, no branch, no memory stall, no hazard expected.
  function automatic vec_t ins(input string nm, input int rs, input int rt, input int urs,
                               input int urt, input int dest, input int rw, input int mr,
                               input int sa, input int sb);
    return mk(nm, 1, rs, rt, urs, urt, dest, rw, mr, 0, 0, 1, 1, 0, 0, sa, sb);
  endfunction

  function automatic vec_t nop(input string nm, input int sa, input int sb);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, sa, sb);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.id_valid        = v.v;
    hz.id_rs           = v.rs;
    hz.id_rt           = v.rt;
    hz.id_use_rs       = v.urs;
    hz.id_use_rt       = v.urt;
    hz.id_dest         = v.dest;
    hz.id_reg_write    = v.rw;
    hz.id_mem_read     = v.mr;
    hz.ex_branch_taken = v.br;
    hz.mem_stall       = v.ms;
  endtask

  task automatic check(input vec_t v);
    chk({v.name, ".pc_we"},       int'(hz.pc_we),       int'(v.pc));
    chk({v.name, ".ifid_we"},     int'(hz.ifid_we),     int'(v.ifid));
    chk({v.name, ".ifid_flush"},  int'(hz.ifid_flush),  int'(v.fl));
    chk({v.name, ".idex_bubble"}, int'(hz.idex_bubble), int'(v.bub));
    chk({v.name, ".fwd_a_sel"},   int'(hz.fwd_a_sel),   int'(v.sa));
    chk({v.name, ".fwd_b_sel"},   int'(hz.fwd_b_sel),   int'(v.sb));
  endtask

  task automatic chk_cnt(input string nm, input int s, input int f);
`ifdef HAZARD_PERF_CNT_EN
    chk({nm, ".stall_cnt"}, int'(hz.stall_cnt), s);
    chk({nm, ".flush_cnt"}, int'(hz.flush_cnt), f);
`else
    chk({nm, ".stall_cnt"}, int'(hz.stall_cnt), 0);
    chk({nm, ".flush_cnt"}, int'(hz.flush_cnt), 0);
`endif
  endtask

  // Drive at posedge+1, check at posedge+3, then step to the next posedge+1.
  task automatic run_vec(input vec_t v);
    drive(v);
    #2;
    check(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t seq[$];
  vec_t v, v2;

  initial begin
    // Forwarding/load-use table; expected sels are those registered on the previous edge.
    tbl.push_back(nop("t0", 0, 0));
    tbl.push_back(ins("t1_add_r1",   2, 3, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(ins("t2_sub_r1",   1, 4, 1, 1, 5, 1, 0, 0, 0));
    tbl.push_back(nop("t3", 2, 0));
    tbl.push_back(ins("t4_add_r6",   0, 0, 0, 0, 6, 1, 0, 0, 0));
    tbl.push_back(nop("t5", 0, 0));
    tbl.push_back(ins("t6_or_r6",    7, 6, 1, 1, 8, 1, 0, 0, 0));
    tbl.push_back(nop("t7", 0, 1));
    tbl.push_back(ins("t8_lw_r2",    9, 0, 1, 0, 2, 1, 1, 0, 0));
    tbl.push_back(mk("t9_ldstall", 1, 2, 2, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(ins("t10_add_go",  2, 2, 1, 1, 10, 1, 0, 0, 0));
    tbl.push_back(nop("t11", 1, 1));
    tbl.push_back(ins("t12_p1_r3",   0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(ins("t13_p2_r3",   0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(ins("t14_c_r3",    3, 3, 1, 1, 11, 1, 0, 0, 0));
    tbl.push_back(ins("t15_r0prod",  0, 0, 0, 0, 0, 1, 0, 2, 2));
    tbl.push_back(ins("t16_r0cons",  0, 12, 1, 1, 13, 1, 0, 0, 0));
    tbl.push_back(nop("t17", 0, 0));
    tbl.push_back(ins("t18_use_off", 13, 13, 0, 0, 14, 0, 0, 0, 0));
    tbl.push_back(nop("t19", 0, 0));
    tbl.push_back(ins("t20_nowr",    14, 0, 1, 0, 15, 1, 0, 0, 0));
    tbl.push_back(nop("t21", 0, 0));

    // Load-use and branch in the same cycle, then a 3-cycle memory freeze.
    seq.push_back(ins("h1_add5", 0, 0, 0, 0, 5, 1, 0, 0, 0));
    seq.push_back(ins("h2_lw4",  0, 0, 0, 0, 4, 1, 1, 0, 0));
    seq.push_back(mk("h3_ld_br", 1, 4, 5, 1, 1, 6, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0));
    seq.push_back(nop("h4", 0, 0));
    seq.push_back(ins("f1_add7", 0, 0, 0, 0, 7, 1, 0, 0, 0));
    seq.push_back(mk("f2_frz",    1, 7, 0, 1, 0, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk("f3_frz",    1, 7, 0, 1, 0, 8, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    seq.push_back(mk("f4_frz_br", 1, 7, 0, 1, 0, 8, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    seq.push_back(ins("f5_go",   7, 0, 1, 0, 8, 1, 0, 0, 0));
    seq.push_back(nop("f6", 2, 0));

    rst_n = 1'b0;
    drive(nop("init", 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check(nop("reset", 0, 0));
    chk_cnt("reset", 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);
    foreach (seq[i]) run_vec(seq[i]);

    // Fresh reset, then two load-use stalls and one flush for the counters.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(ins("c1_lw2", 0, 0, 0, 0, 2, 1, 1, 0, 0));
    run_vec(mk("c2_stall", 1, 2, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run_vec(ins("c3_go",  2, 0, 1, 0, 9, 1, 0, 0, 0));
    run_vec(ins("c4_lw3", 0, 0, 0, 0, 3, 1, 1, 1, 0));
    run_vec(mk("c5_stall", 1, 0, 3, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    run_vec(ins("c6_go",  0, 3, 0, 1, 9, 1, 0, 0, 0));
    run_vec(mk("c7_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1));
    drive(nop("c8", 0, 0));
    #2;
    check(nop("c8", 0, 0));
    chk_cnt("c8", 2, 1);
    @(posedge clk);
    #1;

    // Reset asserted while a load-use stall is being signalled.
    run_vec(ins("r1_lw4", 0, 0, 0, 0, 4, 1, 1, 0, 0));
    v = mk("r2_stall", 1, 4, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(v);
    #2;
    check(v);
    rst_n = 1'b0;
    #1;
    v2 = mk("r2_in_rst", 1, 4, 0, 1, 0, 9, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    check(v2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v2.name = "r3_after_rst";
    drive(v2);
    #2;
    check(v2);
    chk_cnt("r3_after_rst", 0, 0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
